// File: rtl/seq_input_pkg.sv
// Shared types and constants for the sequence-detector input conditioner.
//
// Contents:
//   db_state_t            - debounce FSM state (2-bit encoding)
//   dbg_state_t           - both debounce FSM states, for the debug port
//   DEBOUNCE_CYCLES_BOARD - stable-sample count for board builds
//   DEBOUNCE_CYCLES_SIM   - stable-sample count for simulation
package seq_input_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_t;

  typedef struct packed {
    db_state_t sw;
    db_state_t btn;
  } dbg_state_t;

  localparam int DEBOUNCE_CYCLES_BOARD = 200000;
  localparam int DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a 4-state debounce FSM.
//
// The debounced level changes only after DEBOUNCE_CYCLES consecutive
// synchronized samples at the new level; any opposite sample restarts the
// wait from the old stable state.
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   raw       - asynchronous raw input
//   level     - registered debounced level (1 in HIGH and FALL_WAIT)
//   state_dbg - current FSM state, for observation
module debounce_filter
  import seq_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw,
  output logic      level,
  output db_state_t state_dbg
);

  // The first changed sample loads count 1, so the state flips on the edge
  // where the count would reach DEBOUNCE_CYCLES, i.e. when it holds
  // DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             synced;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;

  assign synced    = sync_q[1];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // level is updated together with the state so that it always equals
  // (state == HIGH || state == FALL_WAIT) without a decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        LOW: begin
          if (synced) begin
            state <= RISE_WAIT;
            cnt   <= ONE;
          end
        end
        RISE_WAIT: begin
          if (!synced) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state <= HIGH;
            cnt   <= '0;
            level <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HIGH: begin
          if (!synced) begin
            state <= FALL_WAIT;
            cnt   <= ONE;
          end
        end
        FALL_WAIT: begin
          if (synced) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_bit_input.sv
// Front-end for the sequence detector: debounces a data switch and a step
// button, and on each clean press offers one bit (the debounced switch
// level) to the detector through a one-entry buffer.
//
// Handshake: x_o is offered while x_valid_o is 1 and is taken on any clock
// edge where x_valid_o && x_ready_i. While x_valid_o is 1 and x_ready_i is
// 0, x_o and x_valid_o hold; x_valid_o only drops after a transfer.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   sw_i        - raw data switch
//   btn_i       - raw step button, active-high
//   x_o         - bit offered to the detector
//   x_valid_o   - x_o is valid
//   x_ready_i   - detector accepts x_o
//   overflow_o  - sticky: a press arrived while the buffer was full
//   clr_ovf_i   - synchronous clear of overflow_o
//   db_sw_o     - debounced switch level
//   db_btn_o    - debounced button level
//   dbg_state   - debounce FSM states of both inputs
module seq_bit_input
  import seq_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_i,
  input  logic       btn_i,
  output logic       x_o,
  output logic       x_valid_o,
  input  logic       x_ready_i,
  output logic       overflow_o,
  input  logic       clr_ovf_i,
  output logic       db_sw_o,
  output logic       db_btn_o,
  output dbg_state_t dbg_state
);

  logic db_btn_q;
  logic press;
  logic xfer;
  logic accept;
  logic drop;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (sw_i),
    .level    (db_sw_o),
    .state_dbg(dbg_state.sw)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (btn_i),
    .level    (db_btn_o),
    .state_dbg(dbg_state.btn)
  );

  // One-cycle press pulse on the debounced rising edge; releases are ignored.
  assign press  = db_btn_o & ~db_btn_q;
  assign xfer   = x_valid_o & x_ready_i;
  // A buffer being drained this cycle counts as free, so back-to-back
  // press and transfer never loses a bit.
  assign accept = press & (~x_valid_o | x_ready_i);
  assign drop   = press & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_btn_q   <= 1'b0;
      x_o        <= 1'b0;
      x_valid_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      db_btn_q <= db_btn_o;

      if (accept) begin
        x_o       <= db_sw_o;
        x_valid_o <= 1'b1;
      end else if (xfer) begin
        x_valid_o <= 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow_o <= 1'b1;
      end else if (clr_ovf_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_bit_input.md
# seq_bit_input

Front-end conditioner for the sequence-detector FSM on the QuickLogic board. It takes a raw data switch and a raw "step" push-button, synchronizes and debounces both, and on each clean button press emits one serial bit (the debounced switch level) to the detector over a valid/ready handshake. It replaces the free-running divided clock as the detector's bit source: one press delivers exactly one `x` bit.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable synchronized samples required before a debounced level changes. The legal minimum is 2; simulation uses 4.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)+1`: width of the debounce counter.

Ports:
- `clk` in 1: system clock (`Sys_Clk0`); single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw_i` in 1: raw data switch, asynchronous.
- `btn_i` in 1: raw step button, active-high, asynchronous.
- `x_o` out 1: bit offered to the detector.
- `x_valid_o` out 1: `x_o` is valid.
- `x_ready_i` in 1: detector accepts `x_o`.
- `overflow_o` out 1: sticky flag; a press was dropped.
- `clr_ovf_i` in 1: synchronous clear of `overflow_o`.
- `db_sw_o` out 1: debounced switch level, for an LED.
- `db_btn_o` out 1: debounced button level, for an LED.

## Operation

- Each raw input passes through a 2-flop synchronizer and then a `debounce_filter`.
- `debounce_filter` is a 4-state FSM:
  - `LOW`: when the synced input is 1, go to `RISE_WAIT` and load count 1.
  - `RISE_WAIT`: while the input is 1, increment the count. When the count reaches `DEBOUNCE_CYCLES`, go to `HIGH`. If the input is 0, return to `LOW` with count 0.
  - `HIGH`: the mirror of `LOW`. When the synced input is 0, go to `FALL_WAIT` and load count 1.
  - `FALL_WAIT`: the mirror of `RISE_WAIT`. It reaches `LOW` on terminal count, or returns to `HIGH` on a glitch.
  - The debounced output is 1 in `HIGH` and `FALL_WAIT`, and 0 otherwise.
- Press event: a rising edge of the debounced button (registered previous level), one cycle wide. Releases generate nothing.
- On a press event:
  - If the one-entry buffer is empty, or is being drained this cycle (`x_valid_o && x_ready_i`): load `x_o` with `db_sw_o` as of that same cycle and set `x_valid_o`.
  - Otherwise: drop the press, keep `x_o` and `x_valid_o` unchanged, and set `overflow_o`.
- Transfer happens on any cycle with `x_valid_o && x_ready_i`. If no press arrives in the same cycle, `x_valid_o` clears on the next edge.
- `overflow_o` stays set until `clr_ovf_i` is high at a clock edge or `rst_n` is asserted. If a set and a clear coincide, the set wins.
- Reset values: `x_o`=0, `x_valid_o`=0, `overflow_o`=0, `db_sw_o`=0, `db_btn_o`=0, synchronizers 0, both FSMs in `LOW` with count 0.
- Reset mid-debounce abandons the count. A button held through reset release produces one press after the full debounce time.

## Timing

- Raw to synced: 2 cycles.
- Debounced level: changes `DEBOUNCE_CYCLES` cycles after the first changed synced sample, if the input is stable throughout. Any opposite sample restarts the count.
- Press to valid: `x_valid_o` rises 1 cycle after `db_btn_o` rises. Total latency from a clean raw edge is `DEBOUNCE_CYCLES`+3 cycles.
- `x_o` is stable whenever `x_valid_o` is 1 and `x_ready_i` is 0. `x_valid_o` never drops without a transfer.
- The switch value must be debounced before the press is registered. A switch change within the press cycle is not captured.

## Structure

- Package `seq_input_pkg`:
  - the debounce state enum `LOW`, `RISE_WAIT`, `HIGH`, `FALL_WAIT` (2-bit encoding);
  - the default `DEBOUNCE_CYCLES` for board builds (200000) and for simulation (4).
- Sub-module `debounce_filter`, with parameters `DEBOUNCE_CYCLES` and `CNT_W`. It contains the synchronizer, the FSM and the counter, and is instantiated twice.
- The top level holds edge detection, the one-entry buffer, handshake logic and the overflow flag.

## Test plan

Unless stated otherwise, `DEBOUNCE_CYCLES`=4.

1. **Clean press:** with `sw_i`=1 stable, raise `btn_i` for 10 cycles while `x_ready_i`=1. Required: `x_valid_o` high for exactly 1 cycle with `x_o`=1, 7 cycles after the raw edge; nothing on release.
2. **Bounce rejection:** toggle `btn_i` 1,0,1,0 on alternate cycles, then hold it at 0. Required: `db_btn_o` stays 0 and `x_valid_o` never rises.
3. **Backpressure and overflow:** with `x_ready_i`=0, make two presses with `sw_i`=0 and then 1. Required: `x_o`=0 is held, the second press is dropped and `overflow_o`=1. Then raise `x_ready_i` for 1 cycle: `x_valid_o`=0 next cycle and `overflow_o` stays 1 until `clr_ovf_i`.
4. **Simultaneous drain and press:** assert `x_ready_i` in the same cycle as a new press event. Required: `x_valid_o` stays 1 with the new bit loaded and `overflow_o`=0.
5. **Reset mid-operation:** assert `rst_n`=0 during `RISE_WAIT` and while `x_valid_o`=1. Required: all outputs are 0 immediately, asynchronously. If `btn_i` is held, exactly one press appears 7 cycles after reset release.
6. **Detector sequence:** drive the presses 0,0,1,1 into the detector. Required: 4 transfers in order, with the detector reaching `s4` (`y`=0).
